// File: rtl/vs_array_store.sv
// vs_array_store: single-clock array store that clears every entry to INIT_VALUE, then serves valid/ready writes and reads.
// Optional feature macro ARRAY_BOUNDS_CHECK_EN adds a sticky out-of-range err flag; otherwise err is tied low.
module vs_array_store #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 8,
    parameter int               ADDR_W     = 3,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              err
);
    // state   | meaning
    // INITIAL | single cycle after reset release
    // CLEAR   | writing INIT_VALUE to arr[clear_ptr], one entry per cycle
    // SERVE   | accepting write and read requests
    typedef enum logic [1:0] {INITIAL = 2'd0, CLEAR = 2'd1, SERVE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic [WIDTH-1:0]  arr_q [DEPTH];
    logic [WIDTH-1:0]  arr_d [DEPTH];

    logic              serve_open;
    logic              wr_acc, rd_acc;
    logic              wr_in_range, rd_in_range;
    logic [WIDTH-1:0]  rd_word;

    assign serve_open    = (state_q == SERVE) && !clr;
    assign wr_ready      = serve_open;
    assign rd_ready      = serve_open;
    assign wr_acc        = wr_valid && serve_open;
    assign rd_acc        = rd_valid && serve_open;
    assign busy          = (state_q != SERVE);
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;

    // Decode by matching each entry so addresses past DEPTH simply hit nothing.
    always_comb begin
        wr_in_range = 1'b0;
        rd_in_range = 1'b0;
        rd_word     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) wr_in_range = 1'b1;
            if (rd_addr == ADDR_W'(i)) begin
                rd_in_range = 1'b1;
                rd_word     = arr_q[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        clear_ptr_d     = clear_ptr_q;
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;
        case (state_q)
            INITIAL: begin
                state_d     = CLEAR;
                clear_ptr_d = '0;
            end
            CLEAR: begin
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = SERVE;
                    clear_ptr_d = '0;
                end
            end
            SERVE: begin
                if (clr) begin
                    state_d     = CLEAR;
                    clear_ptr_d = '0;
                end else if (rd_acc) begin
                    rd_data_valid_d = 1'b1;
                    rd_data_d       = rd_in_range ? rd_word : '0;
                end
            end
            default: state_d = INITIAL;
        endcase
    end

    // Reads sample arr_q before this edge's write lands, giving read-before-write.
    always_comb begin
        arr_d = arr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q == CLEAR && clear_ptr_q == ADDR_W'(i)) begin
                arr_d[i] = INIT_VALUE;
            end else if (wr_acc && wr_addr == ADDR_W'(i)) begin
                arr_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        arr_q <= arr_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= INITIAL;
            clear_ptr_q     <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_ptr_q     <= clear_ptr_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

`ifdef ARRAY_BOUNDS_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vs_array_store.sv
// Bench for vs_array_store: DEPTH=8 and DEPTH=6 instances share one stimulus stream and are checked against an array model.
module tb_vs_array_store;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clr, wr_valid, rd_valid;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    logic        wr_ready8, rd_ready8, rdv8, busy8, err8;
    logic [31:0] rd_data8;
    logic        wr_ready6, rd_ready6, rdv6, busy6, err6;
    logic [31:0] rd_data6;

    vs_array_store #(.WIDTH(32), .DEPTH(8), .ADDR_W(3), .INIT_VALUE(32'h0)) u8 (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready8), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready8), .rd_addr(rd_addr),
        .rd_data_valid(rdv8), .rd_data(rd_data8), .busy(busy8), .err(err8));

    vs_array_store #(.WIDTH(32), .DEPTH(6), .ADDR_W(3), .INIT_VALUE(32'h0)) u6 (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready6), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready6), .rd_addr(rd_addr),
        .rd_data_valid(rdv6), .rd_data(rd_data6), .busy(busy6), .err(err6));

`ifdef ARRAY_BOUNDS_CHECK_EN
    localparam logic ERR_ON_OOR = 1'b1;
`else
    localparam logic ERR_ON_OOR = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining busy cycles plus a plain array; a sweep is modelled as an instant clear
    // because nothing can observe the array while busy.
    int          depth_m [2] = '{8, 6};
    logic [31:0] mem_m   [2][8];
    int          busy_left [2];
    logic [31:0] exp_rd  [2];
    logic        exp_vld [2];
    logic        exp_err [2];

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                busy_left[k] = 1 + depth_m[k];
                exp_rd[k]    = 32'h0;
                exp_vld[k]   = 1'b0;
                exp_err[k]   = 1'b0;
                for (int j = 0; j < 8; j++) mem_m[k][j] = 32'h0;
            end else if (busy_left[k] > 0) begin
                busy_left[k] = busy_left[k] - 1;
                exp_vld[k]   = 1'b0;
            end else if (clr) begin
                busy_left[k] = depth_m[k];
                exp_vld[k]   = 1'b0;
                for (int j = 0; j < 8; j++) mem_m[k][j] = 32'h0;
            end else begin
                exp_vld[k] = rd_valid;
                if (rd_valid) begin
                    if (int'(rd_addr) < depth_m[k]) exp_rd[k] = mem_m[k][rd_addr];
                    else begin
                        exp_rd[k] = 32'h0;
                        if (ERR_ON_OOR) exp_err[k] = 1'b1;
                    end
                end
                if (wr_valid) begin
                    if (int'(wr_addr) < depth_m[k]) mem_m[k][wr_addr] = wr_data;
                    else if (ERR_ON_OOR) exp_err[k] = 1'b1;
                end
            end
        end
    end

    task automatic cmp_one(input int k, input logic b, input logic wrr, input logic rdr,
                           input logic v, input logic [31:0] d, input logic e);
        logic exp_busy;
        exp_busy = (busy_left[k] > 0);
        chk($sformatf("cyc%0d.busy", k), {31'b0, b}, {31'b0, exp_busy});
        chk($sformatf("cyc%0d.wr_ready", k), {31'b0, wrr}, {31'b0, !exp_busy && !clr});
        chk($sformatf("cyc%0d.rd_ready", k), {31'b0, rdr}, {31'b0, !exp_busy && !clr});
        chk($sformatf("cyc%0d.rd_data_valid", k), {31'b0, v}, {31'b0, exp_vld[k]});
        chk($sformatf("cyc%0d.rd_data", k), d, exp_rd[k]);
        chk($sformatf("cyc%0d.err", k), {31'b0, e}, {31'b0, exp_err[k]});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_one(0, busy8, wr_ready8, rd_ready8, rdv8, rd_data8, err8);
            cmp_one(1, busy6, wr_ready6, rd_ready6, rdv6, rd_data6, err6);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = 3'd0; rd_addr = 3'd0; wr_data = 32'h0;
    endtask

    task automatic count_busy(output int n8, output int n6);
        n8 = 0;
        n6 = 0;
        for (int c = 0; c < 100 && (busy8 || busy6); c++) begin
            if (busy8) n8++;
            if (busy6) n6++;
            step();
        end
    endtask

    task automatic read_at(input logic [2:0] a);
        rd_valid = 1'b1; rd_addr = a;
        step();
        rd_valid = 1'b0;
    endtask

    task automatic write_at(input logic [2:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    int n8, n6;

    initial begin
        reset = 1'b0;
        idle_inputs();
        step();
        cmp_en = 1'b1;
        step();
        chk("reset.busy", {31'b0, busy8}, 32'd1);
        chk("reset.rd_data", rd_data8, 32'h0);

        // 1: sweep length after release, then every entry reads INIT_VALUE
        reset = 1'b1;
        count_busy(n8, n6);
        chk("t1.busy_cycles8", n8, 32'd9);
        chk("t1.busy_cycles6", n6, 32'd7);
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1; rd_addr = 3'(i);
            step();
            chk("t1.rd_valid", {31'b0, rdv8}, 32'd1);
            chk("t1.rd_data", rd_data8, 32'h0);
        end
        rd_valid = 1'b0;
        step();
        chk("t1.valid_drop", {31'b0, rdv8}, 32'd0);

        // 2: write then read back
        write_at(3'd3, 32'hDEADBEEF);
        read_at(3'd3);
        chk("t2.rd_data", rd_data8, 32'hDEADBEEF);
        chk("t2.rd_valid", {31'b0, rdv8}, 32'd1);
        step();
        chk("t2.pulse_len", {31'b0, rdv8}, 32'd0);
        chk("t2.held", rd_data8, 32'hDEADBEEF);

        // 3: read-before-write on the same address
        write_at(3'd5, 32'h22);
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 32'h11;
        rd_valid = 1'b1; rd_addr = 3'd5;
        step();
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("t3.old", rd_data8, 32'h22);
        read_at(3'd5);
        chk("t3.new", rd_data8, 32'h11);

        // 4: clr drops the concurrent write and re-sweeps
        write_at(3'd2, 32'h55);
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 32'h77;
        #1;
        chk("t4.wr_ready", {31'b0, wr_ready8}, 32'd0);
        chk("t4.rd_ready", {31'b0, rd_ready8}, 32'd0);
        step();
        clr = 1'b0; wr_valid = 1'b0;
        count_busy(n8, n6);
        chk("t4.busy_cycles8", n8, 32'd8);
        chk("t4.busy_cycles6", n6, 32'd6);
        read_at(3'd2);
        chk("t4.rd_after_clr", rd_data8, 32'h0);

        // 5: out-of-range on the DEPTH=6 instance
        write_at(3'd7, 32'h99);
        read_at(3'd7);
        chk("t5.oor_data", rd_data6, 32'h0);
        chk("t5.oor_valid", {31'b0, rdv6}, 32'd1);
        chk("t5.oor_err", {31'b0, err6}, {31'b0, ERR_ON_OOR});
        chk("t5.inrange_data", rd_data8, 32'h99);
        chk("t5.inrange_err", {31'b0, err8}, 32'd0);

        // 6: reset mid-read and mid-sweep
        write_at(3'd1, 32'hA5A5A5A5);
        read_at(3'd1);
        chk("t6.pre", rd_data8, 32'hA5A5A5A5);
        reset = 1'b0;
        #1;
        chk("t6.rdv_lost", {31'b0, rdv8}, 32'd0);
        chk("t6.rd_zero", rd_data8, 32'h0);
        chk("t6.err_zero", {31'b0, err6}, 32'd0);
        step();
        reset = 1'b1;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("t6.busy_mid", {31'b0, busy8}, 32'd1);
        chk("t6.rd_mid", rd_data8, 32'h0);
        step();
        reset = 1'b1;
        count_busy(n8, n6);
        chk("t6.busy_cycles8", n8, 32'd9);
        for (int i = 0; i < 8; i++) begin
            read_at(3'(i));
            chk("t6.rd_zero_all", rd_data8, 32'h0);
        end

        // Random traffic with occasional clr and reset
        for (int c = 0; c < 4000; c++) begin
            wr_valid = ($urandom_range(0, 99) < 60);
            rd_valid = ($urandom_range(0, 99) < 60);
            wr_addr  = 3'($urandom_range(0, 7));
            rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            wr_data  = $urandom;
            clr      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) reset = 1'b0;
            else if (!reset && $urandom_range(0, 1) == 0) reset = 1'b1;
            step();
        end
        reset = 1'b1;
        idle_inputs();
        repeat (12) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
